// File: rtl/alu_pkg.sv
// Shared encodings for the sequential SM83-style ALU: opcode groups, flag masks, FSM states.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBC = 3'd3,
      OP_AND = 3'd4, OP_XOR = 3'd5, OP_OR  = 3'd6, OP_CP  = 3'd7
   } base_op_t;

   typedef enum logic [2:0] {
      EX_RLC = 3'd0, EX_RRC = 3'd1, EX_RL   = 3'd2, EX_RR  = 3'd3,
      EX_SLA = 3'd4, EX_SRA = 3'd5, EX_SWAP = 3'd6, EX_SRL = 3'd7
   } ext_op_t;

   typedef enum logic [1:0] {MS_DAA = 2'd0, MS_CPL = 2'd1, MS_SCF = 2'd2, MS_CCF = 2'd3} misc_op_t;
   typedef enum logic [1:0] {BO_NONE = 2'd0, BO_BIT = 2'd1, BO_RES = 2'd2, BO_SET = 2'd3} bit_op_t;

   localparam logic [3:0] F_ZERO  = 4'b1000;
   localparam logic [3:0] F_SUB   = 4'b0100;
   localparam logic [3:0] F_HALF  = 4'b0010;
   localparam logic [3:0] F_CARRY = 4'b0001;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

   function automatic logic is_arith(input logic ext, input logic misc, input logic [2:0] op);
      return !ext && !misc && (op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP});
   endfunction

   function automatic logic [3:0] mk_flags(input logic z, input logic n, input logic h, input logic c);
      return (z ? F_ZERO : 4'b0) | (n ? F_SUB : 4'b0) | (h ? F_HALF : 4'b0) | (c ? F_CARRY : 4'b0);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the micro-sequencer (master) and alu_seq (slave).
interface alu_seq_if;
   import alu_pkg::*;

   // A transfer happens on a clock edge where valid && ready; the sender holds
   // valid and its payload stable until then, and ready may depend only on state.
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [2:0]  bit_sel;
   logic        ext;
   logic        misc;
   logic        size;
   logic [15:0] a_data;
   logic [15:0] b_data;
   logic [3:0]  flags_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] res;
   logic [3:0]  flags;
   logic        busy;
   state_t      dbg_state;

   modport master (
      output in_valid, op, bit_sel, ext, misc, size, a_data, b_data, flags_in, out_ready,
      input  in_ready, out_valid, res, flags, busy, dbg_state
   );

   modport slave (
      input  in_valid, op, bit_sel, ext, misc, size, a_data, b_data, flags_in, out_ready,
      output in_ready, out_valid, res, flags, busy, dbg_state
   );

endinterface

// File: rtl/alu_slice_add.sv
// One SLICE_W-bit add/subtract step with carry/borrow chaining and a bit-3 carry tap.
module alu_slice_add #(
   parameter int SLICE_W = 4
) (
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               sub,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout,
   output logic               c3
);
   logic [SLICE_W:0] full;
   logic [4:0]       low;

   // In subtract mode cin/cout are borrows; the wrapped top bit is the borrow out.
   always_comb begin
      if (sub) begin
         full = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, cin};
         low  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0000, cin};
      end else begin
         full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
         low  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
      end
   end

   assign sum  = full[SLICE_W-1:0];
   assign cout = full[SLICE_W];
   assign c3   = low[4];

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle SM83 ALU: slice-serial carry-chain ops, single-cycle logic/shift/bit ops.
module alu_seq
   import alu_pkg::*;
#(
   parameter int SLICE_W  = 4,
   parameter bit ALLOW_16 = 1'b1
) (
   input logic      clk,
   input logic      rst,
   alu_seq_if.slave bus
);
   localparam int N8  = 8 / SLICE_W;
   localparam int N16 = 16 / SLICE_W;

   state_t             state;
   logic [15:0]        a_r, b_r, acc, res_r, next_acc, arith_res;
   logic [2:0]         op_r, bit_sel_r;
   logic               ext_r, misc_r, wide_r, arith_r, carry_r, h_r, out_valid_r;
   logic [3:0]         flags_r, flags_o, arith_flags, l_flags;
   logic [1:0]         idx, last_idx, h_idx;
   logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
   logic               sl_cout, sl_c3, sub_op, c_in, n_in, h_in, h_now, sh_c, daa_c;
   logic [7:0]         a8, b8, l_res, daa_corr;

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.dbg_state = state;
   assign bus.out_valid = out_valid_r;
   assign bus.res       = res_r;
   assign bus.flags     = flags_o;

   assign sub_op   = op_r inside {OP_SUB, OP_SBC, OP_CP};
   assign c_in     = |(flags_r & F_CARRY);
   assign n_in     = |(flags_r & F_SUB);
   assign h_in     = |(flags_r & F_HALF);
   assign a8       = a_r[7:0];
   assign b8       = b_r[7:0];
   assign last_idx = wide_r ? 2'(N16 - 1) : 2'(N8 - 1);
   // Slice that contains bit 3 (8-bit) or bit 11 (16-bit) supplies H.
   assign h_idx    = wide_r ? 2'(11 / SLICE_W) : 2'(3 / SLICE_W);
   assign sl_a     = SLICE_W'(a_r >> (idx * SLICE_W));
   assign sl_b     = SLICE_W'(b_r >> (idx * SLICE_W));

   alu_slice_add #(.SLICE_W(SLICE_W)) u_slice (
      .a(sl_a), .b(sl_b), .sub(sub_op), .cin(carry_r),
      .sum(sl_sum), .cout(sl_cout), .c3(sl_c3)
   );

   always_comb begin
      next_acc = acc | (16'(sl_sum) << (idx * SLICE_W));
      h_now    = (idx == h_idx) ? sl_c3 : h_r;
      if (wide_r) begin
         arith_res   = next_acc;
         arith_flags = mk_flags(|(flags_r & F_ZERO), 1'b0, h_now, sl_cout);
      end else begin
         arith_res   = {8'h00, (op_r == OP_CP) ? a8 : next_acc[7:0]};
         arith_flags = mk_flags(next_acc[7:0] == 8'h00, sub_op, h_now, sl_cout);
      end
   end

   // Single-cycle datapath for logic, misc, CB shift and CB bit operations.
   always_comb begin
      l_res    = a8;
      l_flags  = flags_r;
      sh_c     = 1'b0;
      daa_corr = 8'h00;
      daa_c    = c_in;
      if (ext_r && misc_r) begin
         case (op_r[1:0])
            BO_BIT:  l_flags = mk_flags(~a8[bit_sel_r], 1'b0, 1'b1, c_in);
            BO_RES:  l_res[bit_sel_r] = 1'b0;
            BO_SET:  l_res[bit_sel_r] = 1'b1;
            default: l_res = a8;
         endcase
      end else if (ext_r) begin
         case (op_r)
            EX_RLC:  begin l_res = {a8[6:0], a8[7]}; sh_c = a8[7]; end
            EX_RRC:  begin l_res = {a8[0], a8[7:1]}; sh_c = a8[0]; end
            EX_RL:   begin l_res = {a8[6:0], c_in};  sh_c = a8[7]; end
            EX_RR:   begin l_res = {c_in, a8[7:1]};  sh_c = a8[0]; end
            EX_SLA:  begin l_res = {a8[6:0], 1'b0};  sh_c = a8[7]; end
            EX_SRA:  begin l_res = {a8[7], a8[7:1]}; sh_c = a8[0]; end
            EX_SWAP: begin l_res = {a8[3:0], a8[7:4]}; sh_c = 1'b0; end
            default: begin l_res = {1'b0, a8[7:1]};  sh_c = a8[0]; end
         endcase
         l_flags = mk_flags(l_res == 8'h00, 1'b0, 1'b0, sh_c);
      end else if (misc_r) begin
         case (op_r[1:0])
            MS_DAA: begin
               if (n_in) begin
                  daa_corr = (c_in ? 8'h60 : 8'h00) | (h_in ? 8'h06 : 8'h00);
                  l_res    = a8 - daa_corr;
               end else begin
                  if (c_in || a8 > 8'h99) begin
                     daa_corr = 8'h60;
                     daa_c    = 1'b1;
                  end
                  if (h_in || a8[3:0] > 4'h9) daa_corr = daa_corr | 8'h06;
                  l_res = a8 + daa_corr;
               end
               l_flags = mk_flags(l_res == 8'h00, n_in, 1'b0, daa_c);
            end
            MS_CPL: begin
               l_res   = ~a8;
               l_flags = flags_r | F_SUB | F_HALF;
            end
            MS_SCF:  l_flags = mk_flags(|(flags_r & F_ZERO), 1'b0, 1'b0, 1'b1);
            default: l_flags = mk_flags(|(flags_r & F_ZERO), 1'b0, 1'b0, ~c_in);
         endcase
      end else begin
         case (op_r)
            OP_AND:  l_res = a8 & b8;
            OP_XOR:  l_res = a8 ^ b8;
            default: l_res = a8 | b8;
         endcase
         l_flags = mk_flags(l_res == 8'h00, 1'b0, op_r == OP_AND, 1'b0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         out_valid_r <= 1'b0;
         res_r       <= '0;
         flags_o     <= '0;
         a_r         <= '0;
         b_r         <= '0;
         acc         <= '0;
         op_r        <= '0;
         bit_sel_r   <= '0;
         flags_r     <= '0;
         ext_r       <= 1'b0;
         misc_r      <= 1'b0;
         wide_r      <= 1'b0;
         arith_r     <= 1'b0;
         carry_r     <= 1'b0;
         h_r         <= 1'b0;
         idx         <= '0;
      end else begin
         case (state)
            S_IDLE: if (bus.in_valid) begin
               a_r       <= bus.a_data;
               b_r       <= bus.b_data;
               op_r      <= bus.op;
               bit_sel_r <= bus.bit_sel;
               ext_r     <= bus.ext;
               misc_r    <= bus.misc;
               flags_r   <= bus.flags_in;
               wide_r    <= ALLOW_16 && bus.size && !bus.ext && !bus.misc && (bus.op == OP_ADD);
               arith_r   <= is_arith(bus.ext, bus.misc, bus.op);
               carry_r   <= is_arith(bus.ext, bus.misc, bus.op) && (bus.op inside {OP_ADC, OP_SBC})
                            && |(bus.flags_in & F_CARRY);
               acc       <= '0;
               h_r       <= 1'b0;
               idx       <= '0;
               state     <= S_EXEC;
            end
            S_EXEC: if (arith_r) begin
               acc     <= next_acc;
               carry_r <= sl_cout;
               if (idx == h_idx) h_r <= sl_c3;
               if (idx == last_idx) begin
                  res_r       <= arith_res;
                  flags_o     <= arith_flags;
                  out_valid_r <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  idx <= idx + 2'd1;
               end
            end else begin
               res_r       <= {8'h00, l_res};
               flags_o     <= l_flags;
               out_valid_r <= 1'b1;
               state       <= S_DONE;
            end
            S_DONE: if (bus.out_ready) begin
               out_valid_r <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (SLICE_W=4, ALLOW_16=1) with hand-computed expected results.
module tb_alu_seq;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alu_seq_if bus();

   alu_seq #(.SLICE_W(4), .ALLOW_16(1'b1)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic e, input logic m, input logic sz, input logic [2:0] o,
                           input logic [2:0] bs, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] f);
      @(negedge clk);
      bus.ext      = e;
      bus.misc     = m;
      bus.size     = sz;
      bus.op       = o;
      bus.bit_sel  = bs;
      bus.a_data   = a;
      bus.b_data   = b;
      bus.flags_in = f;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic release_res();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   task automatic run(input string tag, input logic e, input logic m, input logic sz,
                      input logic [2:0] o, input logic [2:0] bs, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] f, input logic [15:0] er,
                      input logic [3:0] ef, input int el);
      int lat;
      start_op(e, m, sz, o, bs, a, b, f);
      wait_done(lat);
      check({tag, ".res"}, bus.res, er);
      check({tag, ".flags"}, 16'(bus.flags), 16'(ef));
      check({tag, ".lat"}, 16'(lat), 16'(el));
      release_res();
   endtask

   initial begin
      int  lat;
      logic seen;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op        = '0;
      bus.bit_sel   = '0;
      bus.ext       = 1'b0;
      bus.misc      = 1'b0;
      bus.size      = 1'b0;
      bus.a_data    = '0;
      bus.b_data    = '0;
      bus.flags_in  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst.out_valid", 16'(bus.out_valid), 16'h0);
      check("rst.res", bus.res, 16'h0000);
      check("rst.flags", 16'(bus.flags), 16'h0);
      check("rst.busy", 16'(bus.busy), 16'h0);
      check("rst.in_ready", 16'(bus.in_ready), 16'h1);
      check("rst.state", 16'(bus.dbg_state), 16'h0);

      //   tag      ext   misc  size  op    bsel  a         b         f_in     res       flags    lat
      run("add",    1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h003A, 16'h00C6, 4'b0000, 16'h0000, 4'b1011, 2);
      run("sbc",    1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 16'h003B, 16'h002A, 4'b0001, 16'h0010, 4'b0100, 2);
      run("cp",     1'b0, 1'b0, 1'b0, 3'd7, 3'd0, 16'h003B, 16'h002A, 4'b0001, 16'h003B, 4'b0100, 2);
      run("add16",  1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 16'h8A23, 16'h0605, 4'b1000, 16'h9028, 4'b1010, 4);
      run("add_bcd",1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0045, 16'h0038, 4'b0000, 16'h007D, 4'b0000, 2);
      run("daa",    1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 16'h007D, 16'h0000, 4'b0000, 16'h0083, 4'b0000, 1);
      run("swap",   1'b1, 1'b0, 1'b0, 3'd6, 3'd0, 16'h00F0, 16'h0000, 4'b0000, 16'h000F, 4'b0000, 1);
      run("bit7",   1'b1, 1'b1, 1'b0, 3'd1, 3'd7, 16'h007F, 16'h0000, 4'b0001, 16'h007F, 4'b1011, 1);
      run("set0",   1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 16'h007F, 16'h0000, 4'b0101, 16'h007F, 4'b0101, 1);
      run("res7",   1'b1, 1'b1, 1'b0, 3'd2, 3'd7, 16'h00FF, 16'h0000, 4'b1010, 16'h007F, 4'b1010, 1);
      run("and",    1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 16'h00F0, 16'h000F, 4'b0001, 16'h0000, 4'b1010, 1);
      run("sub_h",  1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 16'h0010, 16'h0001, 4'b0000, 16'h000F, 4'b0110, 2);
      run("sbc_wrap",1'b0,1'b0, 1'b0, 3'd3, 3'd0, 16'h0000, 16'h0000, 4'b0001, 16'h00FF, 4'b0111, 2);
      run("sub_sz1",1'b0, 1'b0, 1'b1, 3'd2, 3'd0, 16'h1234, 16'h0001, 4'b0000, 16'h0033, 4'b0100, 2);
      run("rl",     1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 16'h0080, 16'h0000, 4'b0000, 16'h0000, 4'b1001, 1);
      run("cpl",    1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 16'h0035, 16'h0000, 4'b1001, 16'h00CA, 4'b1111, 1);
      run("ccf",    1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 16'h0012, 16'h0000, 4'b1001, 16'h0012, 4'b1000, 1);

      // Consumer stalls in DONE while a new request is offered; nothing may change.
      start_op(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0011, 16'h0022, 4'b0000);
      wait_done(lat);
      check("stall.lat", 16'(lat), 16'd2);
      @(negedge clk);
      bus.a_data   = 16'h00FF;
      bus.b_data   = 16'h00FF;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("stall.out_valid", 16'(bus.out_valid), 16'h1);
         check("stall.res", bus.res, 16'h0033);
         check("stall.flags", 16'(bus.flags), 16'h0);
         check("stall.in_ready", 16'(bus.in_ready), 16'h0);
      end
      bus.in_valid = 1'b0;
      release_res();
      check("stall.drained", 16'(bus.out_valid), 16'h0);
      check("stall.idle", 16'(bus.busy), 16'h0);

      // Reset in the middle of a 16-bit add: no result may ever appear.
      start_op(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 16'hFFFF, 16'h0001, 4'b0000);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst.out_valid", 16'(bus.out_valid), 16'h0);
      check("midrst.in_ready", 16'(bus.in_ready), 16'h1);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1 if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      check("midrst.no_result", 16'(seen), 16'h0);
      check("midrst.idle", 16'(bus.in_ready), 16'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
